// File: rtl/bin_to_bcd_div_seq_pkg.sv
// Shared types and constants for the divider-driven binary-to-BCD sequencer.
package bin_to_bcd_div_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int DEC_RADIX = 10;
    localparam int BCD_W     = 4;

endpackage

// File: rtl/bin_to_bcd_div_seq.sv
// Binary-to-BCD converter that peels off one decimal digit per divide-by-10,
// using an external combinational divider with a fixed settle time.
module bin_to_bcd_div_seq
    import bin_to_bcd_div_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int DIV_LATENCY = 1
) (
    input  logic                         Clk,
    input  logic                         nRst,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [WIDTH-1:0]             InValue,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [BCD_W*DIGITS-1:0]      OutBcd,
    output logic [$clog2(DIGITS+1)-1:0]  OutDigits,
    output logic [WIDTH-1:0]             DivDividend,
    output logic [WIDTH-1:0]             DivDivider,
    input  logic [WIDTH-1:0]             DivQuotient,
    input  logic [WIDTH-1:0]             DivRemainder
);

    localparam int DCNT_W = $clog2(DIGITS + 1);

    state_e                    state_q, state_d;
    logic [WIDTH-1:0]          work_q, work_d;
    logic [BCD_W*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DCNT_W-1:0]         digits_q, digits_d;
    logic [DCNT_W-1:0]         idx_q, idx_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      unused_rem_s;

    // Only the low nibble of the remainder can hold a decimal digit.
    assign unused_rem_s = ^DivRemainder[WIDTH-1:BCD_W];

    assign InReady     = (state_q == ST_IDLE);
    assign OutValid    = (state_q == ST_DONE);
    assign OutBcd      = bcd_q;
    assign OutDigits   = digits_q;
    assign DivDividend = work_q;
    assign DivDivider  = WIDTH'(DEC_RADIX);

    // State and datapath registers; nRst aborts any conversion in flight.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            idx_q    <= '0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update for the issue/wait/capture digit loop.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    work_d  = InValue;
                    bcd_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d = 4'(DIV_LATENCY);
                if (DIV_LATENCY == 0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (idx_q == DCNT_W'(d)) begin
                        bcd_d[d*BCD_W +: BCD_W] = DivRemainder[BCD_W-1:0];
                    end else begin
                        bcd_d[d*BCD_W +: BCD_W] = bcd_q[d*BCD_W +: BCD_W];
                    end
                end
                work_d   = DivQuotient;
                digits_d = idx_q + DCNT_W'(1);
                // Stop early once the quotient runs out: leading zeros are not digits.
                if ((DivQuotient == '0) || (idx_q == DCNT_W'(DIGITS - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + DCNT_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_to_bcd_div_seq.sv
// Randomised self-checking bench: behavioural divider plus decimal reference model.
module tb_bin_to_bcd_div_seq;

    logic        Clk;
    logic        nRst;
    logic        InValid;
    logic        InReady;
    logic [7:0]  InValue;
    logic        OutValid;
    logic        OutReady;
    logic [11:0] OutBcd;
    logic [1:0]  OutDigits;
    logic [7:0]  DivDividend;
    logic [7:0]  DivDivider;
    logic [7:0]  DivQuotient;
    logic [7:0]  DivRemainder;

    int n_checks = 0;
    int n_pass   = 0;

    bin_to_bcd_div_seq #(.WIDTH(8), .DIGITS(3), .DIV_LATENCY(1)) dut (
        .Clk          (Clk),
        .nRst         (nRst),
        .InValid      (InValid),
        .InReady      (InReady),
        .InValue      (InValue),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutBcd       (OutBcd),
        .OutDigits    (OutDigits),
        .DivDividend  (DivDividend),
        .DivDivider   (DivDivider),
        .DivQuotient  (DivQuotient),
        .DivRemainder (DivRemainder)
    );

    // Behavioural combinational divider.
    assign DivQuotient  = (DivDivider == 8'd0) ? 8'hFF : DivDividend / DivDivider;
    assign DivRemainder = (DivDivider == 8'd0) ? 8'hFF : DivDividend % DivDivider;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) << 8) | 12'(((v / 10) % 10) << 4) | 12'(v % 10);
    endfunction

    function automatic int ref_digits(input int v);
        return (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    endfunction

    // Waits (bounded) for OutValid after an accepting edge; returns cycles elapsed.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (OutValid) break;
            if (cyc > 100) begin
                check("timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic pulse_ready(input logic [11:0] exp_bcd);
        @(negedge Clk);
        InValid  = 1'b0;
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        check("ready_after_deliver", 32'(InReady), 32'd1);
        check("valid_after_deliver", 32'(OutValid), 32'd0);
        check("bcd_kept", 32'(OutBcd), 32'(exp_bcd));
    endtask

    task automatic do_conv(input int v, input int hold);
        int cyc;
        logic [11:0] eb;
        eb = ref_bcd(v);
        @(negedge Clk);
        InValid  = 1'b1;
        InValue  = 8'(v);
        OutReady = 1'b0;
        check("in_ready_idle", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("dividend_first", 32'(DivDividend), 32'(v));
        check("divisor", 32'(DivDivider), 32'd10);
        wait_done(cyc);
        check("latency", 32'(cyc), 32'(3 * ref_digits(v)));
        check("bcd", 32'(OutBcd), 32'(eb));
        check("digits", 32'(OutDigits), 32'(ref_digits(v)));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            InValid = 1'b1;
            InValue = 8'($urandom_range(255));
            check("hold_valid", 32'(OutValid), 32'd1);
            check("hold_bcd", 32'(OutBcd), 32'(eb));
            check("hold_in_ready", 32'(InReady), 32'd0);
        end
        pulse_ready(eb);
    endtask

    initial begin
        int cyc;
        int v;
        nRst     = 1'b0;
        InValid  = 1'b0;
        InValue  = 8'd0;
        OutReady = 1'b0;
        #2;
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_out_bcd", 32'(OutBcd), 32'd0);
        check("rst_out_digits", 32'(OutDigits), 32'd0);
        check("rst_dividend", 32'(DivDividend), 32'd0);
        repeat (2) @(negedge Clk);
        nRst = 1'b1;
        #1;
        check("rst_in_ready", 32'(InReady), 32'd1);

        do_conv(137, 0);
        do_conv(0, 0);
        do_conv(7, 0);
        do_conv(42, 0);
        do_conv(255, 5);

        // Reset while the first digit of 200 is settling.
        @(negedge Clk);
        InValid = 1'b1;
        InValue = 8'd200;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(posedge Clk);
        #1;
        nRst = 1'b0;
        #1;
        check("abort_out_valid", 32'(OutValid), 32'd0);
        check("abort_in_ready", 32'(InReady), 32'd1);
        check("abort_bcd", 32'(OutBcd), 32'd0);
        @(negedge Clk);
        nRst = 1'b1;
        do_conv(99, 0);

        // Back-to-back with InValid held: 10 then 100.
        @(negedge Clk);
        InValid = 1'b1;
        InValue = 8'd10;
        @(posedge Clk);
        #1;
        InValue = 8'd100;
        wait_done(cyc);
        check("b2b_first_bcd", 32'(OutBcd), 32'h010);
        check("b2b_first_digits", 32'(OutDigits), 32'd2);
        check("b2b_first_latency", 32'(cyc), 32'd6);
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        check("b2b_idle", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        check("b2b_second_accept", 32'(DivDividend), 32'd100);
        wait_done(cyc);
        check("b2b_second_bcd", 32'(OutBcd), 32'h100);
        check("b2b_second_digits", 32'(OutDigits), 32'd3);
        pulse_ready(12'h100);

        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(255));
            do_conv(v, int'($urandom_range(3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
